// File: rtl/stack_arbiter_if.sv
// Request/grant and response bundle between the two stack requesters and stack_arbiter.
// The hwm port exists only when STACK_ARB_HWM_EN is defined.
interface stack_arbiter_if #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic          req0;
  logic          op0;
  logic [W-1:0]  wdata0;
  logic          gnt0;
  logic          req1;
  logic          op1;
  logic [W-1:0]  wdata1;
  logic          gnt1;
  logic [W-1:0]  rdata;
  logic          rvalid;
  logic          rid;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          clr_err;
  logic          err_ovf;
  logic          err_unf;
`ifdef STACK_ARB_HWM_EN
  logic [AW:0]   hwm;

  modport master (
    output req0, op0, wdata0, req1, op1, wdata1, clr_err,
    input  gnt0, gnt1, rdata, rvalid, rid, count, full, empty, err_ovf, err_unf, hwm
  );
  modport slave (
    input  req0, op0, wdata0, req1, op1, wdata1, clr_err,
    output gnt0, gnt1, rdata, rvalid, rid, count, full, empty, err_ovf, err_unf, hwm
  );
`else
  modport master (
    output req0, op0, wdata0, req1, op1, wdata1, clr_err,
    input  gnt0, gnt1, rdata, rvalid, rid, count, full, empty, err_ovf, err_unf
  );
  modport slave (
    input  req0, op0, wdata0, req1, op1, wdata1, clr_err,
    output gnt0, gnt1, rdata, rvalid, rid, count, full, empty, err_ovf, err_unf
  );
`endif
endinterface

// File: rtl/stack_arbiter.sv
// Two-requester round-robin arbiter serialising push/pop onto a register-array LIFO.
// Define STACK_ARB_HWM_EN to add the hwm (high-water mark) output.
module stack_arbiter #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  stack_arbiter_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {ARB, EXEC, RESP} state_t;

  state_t         state_q;
  logic [W-1:0]   mem_q [DEPTH];
  logic [AW:0]    sp_q;
  logic           last_id_q;
  logic           id_q;
  logic           op_q;
  logic [W-1:0]   wdata_q;
  logic [W-1:0]   rdata_q;
  logic           gnt0_q;
  logic           gnt1_q;
  logic           rvalid_q;
  logic           rid_q;
  logic           err_ovf_q;
  logic           err_unf_q;

  logic           full_c;
  logic           empty_c;
  logic           win_c;
  logic           wr_en_c;
  logic [AW-1:0]  rd_idx_c;

  assign full_c   = (sp_q == (AW+1)'(DEPTH));
  assign empty_c  = (sp_q == '0);
  // Tie goes to whoever did not win last; a lone requester always wins.
  assign win_c    = (bus.req0 && bus.req1) ? ~last_id_q : bus.req1;
  assign wr_en_c  = (state_q == EXEC) && op_q && !full_c;
  assign rd_idx_c = AW'(sp_q - (AW+1)'(1));

  // Storage is not reset; only the pointer defines valid contents.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem_q[sp_q[AW-1:0]] <= wdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB;
      sp_q      <= '0;
      last_id_q <= 1'b1;
      id_q      <= 1'b0;
      op_q      <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid_q  <= 1'b0;
      rid_q     <= 1'b0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rid_q    <= 1'b0;
      // Clear first so a same-edge error set below takes priority.
      if (bus.clr_err) begin
        err_ovf_q <= 1'b0;
        err_unf_q <= 1'b0;
      end
      case (state_q)
        ARB: begin
          if (bus.req0 || bus.req1) begin
            id_q      <= win_c;
            last_id_q <= win_c;
            op_q      <= win_c ? bus.op1 : bus.op0;
            wdata_q   <= win_c ? bus.wdata1 : bus.wdata0;
            gnt0_q    <= ~win_c;
            gnt1_q    <= win_c;
            state_q   <= EXEC;
          end
        end
        EXEC: begin
          if (op_q) begin
            if (full_c) err_ovf_q <= 1'b1;
            else        sp_q      <= sp_q + (AW+1)'(1);
            state_q <= ARB;
          end else begin
            if (empty_c) begin
              rdata_q   <= '0;
              err_unf_q <= 1'b1;
            end else begin
              rdata_q <= mem_q[rd_idx_c];
              sp_q    <= sp_q - (AW+1)'(1);
            end
            rvalid_q <= 1'b1;
            rid_q    <= id_q;
            state_q  <= RESP;
          end
        end
        RESP:    state_q <= ARB;
        default: state_q <= ARB;
      endcase
    end
  end

`ifdef STACK_ARB_HWM_EN
  logic [AW:0] hwm_q;
  logic [AW:0] hwm_base_c;

  assign hwm_base_c = bus.clr_err ? sp_q : hwm_q;

  // Tracks the pointer on the same edge that raises it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hwm_q <= '0;
    end else if (wr_en_c && ((sp_q + (AW+1)'(1)) > hwm_base_c)) begin
      hwm_q <= sp_q + (AW+1)'(1);
    end else begin
      hwm_q <= hwm_base_c;
    end
  end

  assign bus.hwm = hwm_q;
`endif

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.rdata   = rdata_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rid     = rid_q;
  assign bus.count   = sp_q;
  assign bus.full    = full_c;
  assign bus.empty   = empty_c;
  assign bus.err_ovf = err_ovf_q;
  assign bus.err_unf = err_unf_q;
endmodule

// File: tb/tb_stack_arbiter.sv
// Directed, table-driven bench for stack_arbiter (DEPTH=16, W=8).
module tb_stack_arbiter;
  localparam int unsigned W     = 8;
  localparam int unsigned DEPTH = 16;

  typedef struct {
    bit         req;
    bit         rq;
    bit         op;
    logic [7:0] wd;
    bit         clr;
    logic [7:0] exp_rdata;
    int         exp_count;
    bit         exp_ovf;
    bit         exp_unf;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  stack_arbiter_if #(.W(W), .DEPTH(DEPTH)) bus ();

  stack_arbiter #(.W(W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic vec_t mk(input bit req, input bit rq, input bit op, input int wd,
                              input bit clr, input int rd, input int cnt,
                              input bit ovf, input bit unf);
    vec_t v;
    v.req = req; v.rq = rq; v.op = op; v.wd = 8'(wd); v.clr = clr;
    v.exp_rdata = 8'(rd); v.exp_count = cnt; v.exp_ovf = ovf; v.exp_unf = unf;
    return v;
  endfunction

  // Waits up to 4 cycles for a grant; a timeout counts as a failure.
  task automatic wait_gnt(input string tag, output int id);
    bit got = 1'b0;
    id = -1;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (bus.gnt0 || bus.gnt1) begin
        got = 1'b1;
        id  = bus.gnt1 ? 1 : 0;
        chk({tag, " gnt_onehot"}, int'(bus.gnt0) + int'(bus.gnt1), 1);
      end
    end
    if (!got) chk({tag, " gnt_timeout"}, 0, 1);
  endtask

  task automatic check_state(input string tag, input int cnt, input bit ovf, input bit unf);
    chk({tag, " count"}, int'(bus.count), cnt);
    chk({tag, " full"},  int'(bus.full),  (cnt == DEPTH) ? 1 : 0);
    chk({tag, " empty"}, int'(bus.empty), (cnt == 0) ? 1 : 0);
    chk({tag, " ovf"},   int'(bus.err_ovf), int'(ovf));
    chk({tag, " unf"},   int'(bus.err_unf), int'(unf));
  endtask

  // Applies one transaction starting from ARB; clr (if set) covers the EXEC edge.
  task automatic run_row(input string tag, input vec_t v);
    int id;
    if (!v.req) begin
      bus.clr_err = v.clr;
      @(negedge clk);
      bus.clr_err = 1'b0;
    end else begin
      if (v.rq) begin
        bus.req1 = 1'b1; bus.op1 = v.op; bus.wdata1 = v.wd;
      end else begin
        bus.req0 = 1'b1; bus.op0 = v.op; bus.wdata0 = v.wd;
      end
      wait_gnt(tag, id);
      chk({tag, " gnt_id"}, id, int'(v.rq));
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      bus.clr_err = v.clr;
      @(negedge clk);
      bus.clr_err = 1'b0;
      if (!v.op) begin
        chk({tag, " rvalid"}, int'(bus.rvalid), 1);
        chk({tag, " rid"},    int'(bus.rid), int'(v.rq));
        chk({tag, " rdata"},  int'(bus.rdata), int'(v.exp_rdata));
        @(negedge clk);
        chk({tag, " rvalid_drop"}, int'(bus.rvalid), 0);
      end
    end
    check_state(tag, v.exp_count, v.exp_ovf, v.exp_unf);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.clr_err = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vec_t tbl[$];
    int   id;
    logic [7:0] da, db;
    int   exp_id;

    bus.req0 = 1'b0; bus.op0 = 1'b0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.op1 = 1'b0; bus.wdata1 = '0;
    bus.clr_err = 1'b0;
    do_reset();

    chk("rst gnt0",   int'(bus.gnt0), 0);
    chk("rst gnt1",   int'(bus.gnt1), 0);
    chk("rst rvalid", int'(bus.rvalid), 0);
    chk("rst rid",    int'(bus.rid), 0);
    chk("rst rdata",  int'(bus.rdata), 0);
    check_state("rst", 0, 1'b0, 1'b0);

    // LIFO order, empty-pop handling, then fill to overflow.
    tbl.push_back(mk(1, 0, 1, 'h11, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 'h22, 0, 0, 2, 0, 0));
    tbl.push_back(mk(1, 0, 1, 'h33, 0, 0, 3, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,     0, 'h33, 2, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,     0, 'h22, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,     0, 'h11, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,     0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0,     1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0,     1, 0, 0, 0, 0));
    for (int k = 1; k <= 16; k++) tbl.push_back(mk(1, 1, 1, k, 0, 0, k, 0, 0));
    tbl.push_back(mk(1, 1, 1, 'h77, 0, 0, 16, 1, 0));
    tbl.push_back(mk(1, 1, 0, 0,     0, 16, 15, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,     1, 0, 15, 0, 0));

    for (int i = 0; i < tbl.size(); i++) run_row($sformatf("row%0d", i), tbl[i]);

    // Continuous contention: strict alternation starting with requester 0.
    do_reset();
    da = 8'hA0; db = 8'hB0;
    bus.req0 = 1'b1; bus.op0 = 1'b1; bus.wdata0 = da;
    bus.req1 = 1'b1; bus.op1 = 1'b1; bus.wdata1 = db;
    for (int g = 0; g < 6; g++) begin
      wait_gnt($sformatf("tie%0d", g), id);
      exp_id = g % 2;
      chk($sformatf("tie%0d gnt_id", g), id, exp_id);
      if (id == 0) begin da = da + 8'd1; bus.wdata0 = da; end
      if (id == 1) begin db = db + 8'd1; bus.wdata1 = db; end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(negedge clk);
    check_state("tie_fill", 6, 1'b0, 1'b0);
    run_row("tie_pop0", mk(1, 0, 0, 0, 0, 'hB2, 5, 0, 0));
    run_row("tie_pop1", mk(1, 1, 0, 0, 0, 'hA2, 4, 0, 0));
    run_row("tie_pop2", mk(1, 0, 0, 0, 0, 'hB1, 3, 0, 0));
    run_row("tie_pop3", mk(1, 0, 0, 0, 0, 'hA1, 2, 0, 0));

    // Pop from 1 pending behind push from 0 with last_id=1 after reset.
    do_reset();
    bus.req0 = 1'b1; bus.op0 = 1'b1; bus.wdata0 = 8'h5C;
    bus.req1 = 1'b1; bus.op1 = 1'b0;
    wait_gnt("mix first", id);
    chk("mix first gnt_id", id, 0);
    bus.req0 = 1'b0;
    wait_gnt("mix second", id);
    chk("mix second gnt_id", id, 1);
    bus.req1 = 1'b0;
    @(negedge clk);
    chk("mix rvalid", int'(bus.rvalid), 1);
    chk("mix rid",    int'(bus.rid), 1);
    chk("mix rdata",  int'(bus.rdata), 'h5C);
    @(negedge clk);
    check_state("mix end", 0, 1'b0, 1'b0);

    // Reset asserted while a pop sits in EXEC: no response may follow.
    do_reset();
    for (int k = 1; k <= 3; k++) run_row($sformatf("pre%0d", k), mk(1, 0, 1, 'h40 + k, 0, 0, k, 0, 0));
    bus.req0 = 1'b1; bus.op0 = 1'b0;
    wait_gnt("abort", id);
    rst = 1'b1;
    bus.req0 = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("abort rvalid%0d", c), int'(bus.rvalid), 0);
    end
    check_state("abort", 0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);

`ifdef STACK_ARB_HWM_EN
    chk("hwm rst", int'(bus.hwm), 0);
    for (int k = 1; k <= 5; k++) run_row($sformatf("hwm_push%0d", k), mk(1, 0, 1, k, 0, 0, k, 0, 0));
    run_row("hwm_pop0", mk(1, 0, 0, 0, 0, 5, 4, 0, 0));
    run_row("hwm_pop1", mk(1, 1, 0, 0, 0, 4, 3, 0, 0));
    chk("hwm peak", int'(bus.hwm), 5);
    run_row("hwm_clr", mk(0, 0, 0, 0, 1, 0, 3, 0, 0));
    chk("hwm reload", int'(bus.hwm), 3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
